// File: rtl/adc_cal_sequencer_pkg.sv
// adc_cal_sequencer_pkg: shared widths, default parameters and one-hot state encoding
package adc_cal_sequencer_pkg;
  localparam int ADC_W = 14;
  localparam int TAP_W = 5;
  localparam int NLANES_DEF = 2;
  localparam int MAX_TAPS_DEF = 32;
  localparam int SETTLE_DEF = 4;
  localparam int PASS_CNT_DEF = 2000;
  typedef enum logic [9:0] {
    S_IDLE     = 10'b00_0000_0001,
    S_CFG_RAMP = 10'b00_0000_0010,
    S_DLY_RST  = 10'b00_0000_0100,
    S_SETTLE   = 10'b00_0000_1000,
    S_CHECK    = 10'b00_0001_0000,
    S_INC      = 10'b00_0010_0000,
    S_NEXT     = 10'b00_0100_0000,
    S_CFG_NORM = 10'b00_1000_0000,
    S_DONE     = 10'b01_0000_0000,
    S_FAIL     = 10'b10_0000_0000
  } state_t;
endpackage

// File: rtl/adc_cal_sequencer_if.sv
// adc_cal_sequencer_if: control, ADC config handshake, delay-line and status signals
interface adc_cal_sequencer_if import adc_cal_sequencer_pkg::*; #(parameter int NLANES = NLANES_DEF);
  logic                      start;
  logic [NLANES*ADC_W-1:0]   adc_data;
  logic                      cfg_req;
  logic                      cfg_ramp;
  logic                      cfg_ack;
  logic                      dly_rst;
  logic [NLANES-1:0]         dly_ce;
  logic [NLANES*TAP_W-1:0]   taps;
  logic                      busy;
  logic                      done;
  logic                      fail;
  modport master (input start, adc_data, cfg_ack,
                  output cfg_req, cfg_ramp, dly_rst, dly_ce, taps, busy, done, fail);
  modport slave  (output start, adc_data, cfg_ack,
                  input cfg_req, cfg_ramp, dly_rst, dly_ce, taps, busy, done, fail);
endinterface

// File: rtl/adc_cal_sequencer_ramp_checker.sv
// ramp_checker: registers one lane and flags a sample that is not previous+1 (mod 2^14)
module ramp_checker import adc_cal_sequencer_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [ADC_W-1:0] i_data,
  output logic             o_vld,
  output logic             o_mismatch
);
  logic [ADC_W-1:0] r_cur, r_prev;
  logic [1:0]       r_fill;
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cur  <= '0;
      r_prev <= '0;
      r_fill <= '0;
    end else if (i_en) begin
      r_cur  <= i_data;
      r_prev <= r_cur;
      r_fill <= {r_fill[0], 1'b1};
    end
  end
  // a verdict needs two samples captured since the last clear
  assign o_vld      = r_fill[1];
  assign o_mismatch = r_fill[1] && (r_cur != ADC_W'(r_prev + 1'b1));
endmodule

// File: rtl/adc_cal_sequencer.sv
// adc_cal_sequencer: per-lane delay-tap sweep against the ADC ramp test pattern
module adc_cal_sequencer import adc_cal_sequencer_pkg::*; #(
  parameter int NLANES   = NLANES_DEF,
  parameter int MAX_TAPS = MAX_TAPS_DEF,
  parameter int SETTLE   = SETTLE_DEF,
  parameter int PASS_CNT = PASS_CNT_DEF
) (
  input logic clk,
  input logic rst,
  adc_cal_sequencer_if.master cal
);
  localparam int SEL_W  = NLANES > 1 ? $clog2(NLANES) : 1;
  localparam int SET_W  = $clog2(SETTLE + 1);
  localparam int PASS_W = $clog2(PASS_CNT + 1);
  state_t            r_state, w_next;
  logic [SEL_W-1:0]  r_sel;
  logic [TAP_W-1:0]  r_taps [NLANES];
  logic [SET_W-1:0]  r_settle;
  logic [PASS_W-1:0] r_pass;
  logic              r_fail;
  logic [ADC_W-1:0]  w_lane;
  logic              w_vld, w_mis, w_idle, w_tap_max, w_pass_done, w_settle_done;
  assign w_lane        = cal.adc_data[int'(r_sel)*ADC_W +: ADC_W];
  assign w_idle        = r_state inside {S_IDLE, S_DONE, S_FAIL};
  assign w_tap_max     = r_taps[r_sel] == TAP_W'(MAX_TAPS - 1);
  assign w_pass_done   = w_vld && !w_mis && r_pass == PASS_W'(PASS_CNT - 1);
  assign w_settle_done = r_settle == SET_W'(SETTLE - 1);
  ramp_checker u_chk (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (r_state == S_SETTLE),
    .i_en       (r_state == S_CHECK),
    .i_data     (w_lane),
    .o_vld      (w_vld),
    .o_mismatch (w_mis)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: w_next = cal.start ? S_CFG_RAMP : r_state;
      S_CFG_RAMP: w_next = cal.cfg_ack ? S_DLY_RST : S_CFG_RAMP;
      S_DLY_RST:  w_next = S_SETTLE;
      S_SETTLE:   w_next = w_settle_done ? S_CHECK : S_SETTLE;
      S_CHECK:    w_next = w_mis ? (w_tap_max ? S_CFG_NORM : S_INC) : w_pass_done ? S_NEXT : S_CHECK;
      S_INC:      w_next = S_SETTLE;
      S_NEXT:     w_next = r_sel == SEL_W'(NLANES - 1) ? S_CFG_NORM : S_SETTLE;
      S_CFG_NORM: w_next = cal.cfg_ack ? (r_fail ? S_FAIL : S_DONE) : S_CFG_NORM;
      default:    w_next = S_IDLE;
    endcase
    cal.cfg_req  = r_state inside {S_CFG_RAMP, S_CFG_NORM};
    cal.cfg_ramp = r_state == S_CFG_RAMP;
    cal.dly_rst  = r_state == S_DLY_RST;
    cal.dly_ce   = r_state == S_INC ? NLANES'(1) << r_sel : '0;
    cal.busy     = !w_idle;
    cal.done     = r_state == S_DONE;
    cal.fail     = r_state == S_FAIL;
  end
  for (genvar g = 0; g < NLANES; g++) begin : g_taps
    assign cal.taps[g*TAP_W +: TAP_W] = r_taps[g];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_settle <= '0;
      r_pass   <= '0;
      r_fail   <= 1'b0;
      for (int i = 0; i < NLANES; i++) r_taps[i] <= '0;
    end else begin
      r_state  <= w_next;
      r_settle <= r_state == S_SETTLE ? r_settle + 1'b1 : '0;
      r_pass   <= r_state == S_CHECK ? r_pass + PASS_W'(w_vld && !w_mis) : '0;
      if (w_idle && cal.start) begin
        r_sel  <= '0;
        r_fail <= 1'b0;
        for (int i = 0; i < NLANES; i++) r_taps[i] <= '0;
      end
      if (r_state == S_NEXT && w_next == S_SETTLE) r_sel <= r_sel + 1'b1;
      if (r_state == S_INC) r_taps[r_sel] <= r_taps[r_sel] + 1'b1;
      if (r_state == S_CHECK && w_mis && w_tap_max) r_fail <= 1'b1;
    end
  end
endmodule

// File: doc/adc_cal_sequencer.md
ADC_CAL_SEQUENCER -- requirements
Module: adc_cal_sequencer

Interface
REQ-001 Parameter NLANES, default 2: number of 14-bit ADC lanes calibrated.
REQ-002 Parameter MAX_TAPS, default 32: delay taps per lane; tap counter width is 5.
REQ-003 Parameter SETTLE, default 4: cycles ignored after any delay change.
REQ-004 Parameter PASS_CNT, default 2000: consecutive ramp-correct samples required per lane.
REQ-005 clk  input  1  ADC clock, nominally 245.76 MHz.
REQ-006 rst  input  1  reset; synchronous, active-high; asserted when the ADC clock loses lock.
REQ-007 start  input  1  one-cycle pulse that begins a calibration run; ignored unless idle.
REQ-008 adc_data  input  NLANES*14  lane data; lane i occupies bits [14i+13:14i].
REQ-009 cfg_req  output  1  request to the ADC configuration port.
REQ-010 cfg_ramp  output  1  requested pattern: 1 = ramp test pattern, 0 = normal data.
REQ-011 cfg_ack  input  1  one-cycle completion pulse from the configuration port.
REQ-012 dly_rst  output  1  one-cycle pulse that returns all lane delays to tap 0.
REQ-013 dly_ce  output  NLANES  one-cycle increment pulse per lane delay.
REQ-014 taps  output  NLANES*5  final tap count per lane.
REQ-015 busy, done, fail  output  1 each  run in progress, run passed, run failed.

Function
REQ-016 States: IDLE, CFG_RAMP, DLY_RST, SETTLE, CHECK, INC, NEXT, CFG_NORM, DONE, FAIL.
REQ-017 IDLE: start=1 -> CFG_RAMP; lane index sel and all tap counters cleared.
REQ-018 CFG_RAMP: cfg_req=1, cfg_ramp=1 held until cfg_ack=1 -> DLY_RST.
REQ-019 DLY_RST: dly_rst=1 for exactly one cycle -> SETTLE.
REQ-020 SETTLE: counts SETTLE cycles, then -> CHECK with pass counter cleared.
REQ-021 CHECK: lane sel sample registered, compared with previous registered sample; mismatch when cur != prev+1 mod 2^14 (16383 -> 0 is a pass).
REQ-022 CHECK: no mismatch -> pass counter +1; pass counter reaching PASS_CNT -> NEXT.
REQ-023 CHECK: mismatch with taps[sel] < MAX_TAPS-1 -> INC; mismatch with taps[sel] = MAX_TAPS-1 -> CFG_NORM with fail flag latched.
REQ-024 INC: dly_ce[sel]=1 for one cycle, taps[sel]+1 -> SETTLE.
REQ-025 NEXT: sel = NLANES-1 -> CFG_NORM; else sel+1 -> SETTLE.
REQ-026 CFG_NORM: cfg_req=1, cfg_ramp=0 until cfg_ack -> FAIL if fail flag latched, else DONE.
REQ-027 DONE and FAIL are terminal until rst or a new start; start from DONE/FAIL restarts at CFG_RAMP.
REQ-028 cfg_ack outside CFG_RAMP/CFG_NORM is ignored.
REQ-029 At most one dly_ce bit is high in any cycle; never coincident with dly_rst.
REQ-030 busy=1 in every state except IDLE, DONE, FAIL; done/fail mutually exclusive, held until restart.
REQ-031 Pass counter and previous-sample register are cleared on every entry to SETTLE.

Reset
REQ-032 rst forces IDLE from any state, including mid-configuration; all outputs 0, taps 0, counters 0, fail flag cleared.
REQ-033 Outstanding cfg_req is withdrawn on rst; no dly_rst is issued by reset itself.

Structure
REQ-034 Shared package holds the state encoding (one-hot), ADC_W=14, TAP_W=5 and default parameter values.
REQ-035 One sub-module, ramp_checker: registers one 14-bit lane, outputs mismatch, clear input for REQ-031.

Verification
REQ-036 Ideal ramp on both lanes, cfg_ack 3 cycles after each cfg_req -> zero dly_ce, taps=0/0, done=1, fail=0.
REQ-037 Lane 0 corrupted until 5 dly_ce pulses, lane 1 clean -> taps[0]=5, taps[1]=0, done=1.
REQ-038 Lane 1 never ramp-correct -> 31 dly_ce[1] pulses, CFG_NORM with cfg_ramp=0 still issued, fail=1, done=0.
REQ-039 Ramp crossing 16383 -> 0 during CHECK -> no mismatch, no dly_ce.
REQ-040 rst asserted while cfg_req high in CFG_RAMP -> next cycle IDLE, cfg_req=0, busy=0; later start runs normally.
REQ-041 start pulsed while busy and stray cfg_ack in CHECK -> no state change, no extra outputs.
